boolean_exp: RTL and testbench
==============================

Name: boolean_exp

Overview:
- Sum-of-products evaluator: Y = (A & B) | (C & D) | E.
- Y is purely combinational and valid without a clock.
- Clocked observation logic (registered copy, per-term flags, rising-edge pulse, optional hit counter) sits on top for use by downstream control and debug.
- Used as a small glue/decode leaf cell.

Parameters:
- CNT_W, 16, width of the saturating hit counter (legal 2..32).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- A  input  1  product-term-0 operand
- B  input  1  product-term-0 operand
- C  input  1  product-term-1 operand
- D  input  1  product-term-1 operand
- E  input  1  single-literal term
- Y  output  1  combinational result (A&B)|(C&D)|E
- terms  output  3  combinational term flags: [0]=A&B, [1]=C&D, [2]=E
- y_q  output  1  Y registered on clk
- y_rise  output  1  one-cycle pulse when Y goes 0->1 (registered)
- hit_count  output  CNT_W  cycles with Y=1, saturating; present only with BEXP_STATS_EN

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Combinational path:
  - Y and terms depend only on A..E; zero latency.
  - Unaffected by clk or rst.
  - No latches.
  - Y == |terms at all times.
- Input X/Z handling: no special handling; standard Verilog operator semantics.
- Registered path, all updates on rising clk:
  - rst=1: y_q=0, y_rise=0, internal y_prev=0, hit_count=0. Reset takes priority over all other updates in that cycle.
  - Otherwise: y_q <= Y; y_prev <= Y; y_rise <= Y & ~y_prev.
  - Consequence: y_rise asserts the cycle after Y is sampled 1 when the previous sample was 0, and stays high for exactly one cycle.
- After reset release, the first sampled Y=1 produces y_rise=1, because y_prev resets to 0.
- A rising edge during the reset cycle is ignored; the next non-reset sample still compares against y_prev=0.
- Glitches on Y between clock edges are not captured by the registered outputs.
- Latency: y_q and y_rise lag the Y sample by 1 cycle; hit_count lags by 1 cycle.

Optional Feature:
- Macro: BEXP_STATS_EN.
- When defined:
  - hit_count port exists.
  - Each non-reset cycle with Y=1 increments hit_count by 1.
  - hit_count saturates at 2^CNT_W-1 and holds there; it does not wrap.
  - rst clears hit_count to 0.
- When undefined:
  - hit_count port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Truth vectors, combinational, no clock needed, 10 ns apart (ABCDE -> Y):
  - 00000 -> 0
  - 11000 -> 1
  - 00110 -> 1
  - 00001 -> 1
  - 11110 -> 1
  - 10111 -> 1
  - terms for 11110 = 3'b011; for 10111 = 3'b110.
- Partial products: 10100 -> Y=0; 01010 -> Y=0; terms=0 in both cases.
- Exhaustive sweep: all 32 input combinations -> Y matches the equation and Y == |terms.
- Reset and edge detection:
  - Hold rst=1 for 2 cycles with E=1 -> y_q=0, y_rise=0.
  - Release rst -> next edge gives y_q=1, y_rise=1; following edge gives y_rise=0 while E stays 1.
- Toggle sequence: Y pattern 0,1,1,0,1 sampled on consecutive edges -> y_rise pattern one cycle later is 0,1,0,0,1.
- With BEXP_STATS_EN and CNT_W=2:
  - Hold E=1 for 5 cycles -> hit_count goes 1,2,3,3,3 (saturated).
  - Assert rst -> hit_count=0 on the next edge.

Source files
------------

// File: rtl/boolean_exp.sv
// boolean_exp: sum-of-products leaf Y = (A&B) | (C&D) | E with
// clocked observation (registered Y, rising-edge pulse, hit counter).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   A,B       product-term-0 operands
//   C,D       product-term-1 operands
//   E         single-literal term
//   Y         combinational result, zero latency
//   terms     term flags {E, C&D, A&B}
//   y_q       Y registered on clk
//   y_rise    one-cycle registered pulse on a 0->1 sample of Y
//   hit_count saturating count of cycles with Y=1
//             (only when BEXP_STATS_EN is defined)
//
// Parameter CNT_W: hit counter width, legal 2..32.
// Macro BEXP_STATS_EN: adds the hit_count port and counter.

module boolean_exp #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   input  logic             D,
   input  logic             E,
   output logic             Y,
   output logic [2:0]       terms,
   output logic             y_q,
   output logic             y_rise
`ifdef BEXP_STATS_EN
   ,
   output logic [CNT_W-1:0] hit_count
`endif
);

   if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
      $error("boolean_exp: CNT_W must be in 2..32");
   end

   // Combinational path: Y is the OR of the term flags, so
   // Y == |terms holds by construction.
   always_comb begin
      terms = {E, C & D, A & B};
   end

   assign Y = |terms;

   logic y_d;
   logic y_prev_q;
   logic y_prev_d;
   logic y_rise_q;
   logic y_rise_d;

   always_comb begin
      y_d      = Y;
      y_prev_d = Y;
      // y_prev restarts at 0 after reset, so the first
      // sampled 1 always produces a pulse.
      y_rise_d = Y & ~y_prev_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q      <= 1'b0;
         y_prev_q <= 1'b0;
         y_rise_q <= 1'b0;
      end else begin
         y_q      <= y_d;
         y_prev_q <= y_prev_d;
         y_rise_q <= y_rise_d;
      end
   end

   assign y_rise = y_rise_q;

`ifdef BEXP_STATS_EN
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne =
      {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] hit_q;
   logic [CNT_W-1:0] hit_d;

   // Saturate rather than wrap so a long-high Y never
   // reads back as a small count.
   always_comb begin
      hit_d = hit_q;
      if (Y && (hit_q != CntMax)) begin
         hit_d = hit_q + CntOne;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_q <= '0;
      end else begin
         hit_q <= hit_d;
      end
   end

   assign hit_count = hit_q;
`endif

endmodule

// File: tb/tb_boolean_exp.sv
// tb_boolean_exp: randomized self-checking bench for boolean_exp
// with a behavioural reference model and pinned literal vectors.

module tb_boolean_exp;

   localparam int CNT_W = 2;

   logic clk;
   logic rst;
   logic A, B, C, D, E;
   logic Y;
   logic [2:0] terms;
   logic y_q;
   logic y_rise;
`ifdef BEXP_STATS_EN
   logic [CNT_W-1:0] hit_count;
`endif

   boolean_exp #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .E         (E),
      .Y         (Y),
      .terms     (terms),
      .y_q       (y_q),
      .y_rise    (y_rise)
`ifdef BEXP_STATS_EN
      ,
      .hit_count (hit_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm,
                      input longint act,
                      input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d @%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Reference: Y is true when both operands of a pair are
   // set (pair sum == 2) or the single literal is set.
   function automatic int ref_y(input logic [4:0] v);
      int ab, cd;
      ab = int'(v[4]) + int'(v[3]);
      cd = int'(v[2]) + int'(v[1]);
      return ((ab == 2) || (cd == 2) || (v[0] == 1'b1))
             ? 1 : 0;
   endfunction

   function automatic int ref_terms(input logic [4:0] v);
      int t;
      t = 0;
      if (int'(v[4]) + int'(v[3]) == 2) t += 1;
      if (int'(v[2]) + int'(v[1]) == 2) t += 2;
      if (v[0]) t += 4;
      return t;
   endfunction

   // Model state for the registered outputs.
   bit     m_valid = 0;
   int     m_yq, m_rise, m_prev;
   longint m_cnt;
   longint m_max = (longint'(1) << CNT_W) - 1;

   // Single compare process: combinational check just before
   // the edge, model update at the edge, registered check 1ns
   // after it.
   always @(posedge clk) begin
      logic [4:0] v;
      int y;
      v = {A, B, C, D, E};
      y = ref_y(v);
      chk("Y", longint'(Y), y);
      chk("terms", longint'(terms), ref_terms(v));
      if (rst) begin
         m_valid = 1;
         m_yq = 0; m_rise = 0; m_prev = 0; m_cnt = 0;
      end else begin
         m_yq   = y;
         m_rise = (y == 1 && m_prev == 0) ? 1 : 0;
         m_prev = y;
         if (y == 1 && m_cnt < m_max) m_cnt++;
      end
      #1;
      if (m_valid) begin
         chk("y_q", longint'(y_q), m_yq);
         chk("y_rise", longint'(y_rise), m_rise);
`ifdef BEXP_STATS_EN
         chk("hit_count", longint'(hit_count), m_cnt);
`endif
      end
   end

   task automatic put(input logic [4:0] v);
      {A, B, C, D, E} = v;
   endtask

   task automatic tick(input logic [4:0] v, input logic r);
      @(negedge clk);
      put(v);
      rst = r;
      @(posedge clk);
      #2;
   endtask

   logic [4:0] tv [8];
   logic [7:0] ty;
   int         tt [8];
   logic [4:0] tgl [5];
   int         rexp [5];

   initial begin
      rst = 1'b1;
      put(5'b00000);

      // Literal truth vectors, pinned independently of model.
      tv[0] = 5'b00000; tv[1] = 5'b11000;
      tv[2] = 5'b00110; tv[3] = 5'b00001;
      tv[4] = 5'b11110; tv[5] = 5'b10111;
      tv[6] = 5'b10100; tv[7] = 5'b01010;
      ty = 8'b0011_1110;
      tt[0] = 0; tt[1] = 1; tt[2] = 2; tt[3] = 4;
      tt[4] = 3; tt[5] = 6; tt[6] = 0; tt[7] = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         put(tv[i]);
         #1;
         chk("lit_Y", longint'(Y), longint'(ty[i]));
         chk("lit_terms", longint'(terms), tt[i]);
      end

      // Exhaustive sweep against the model.
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         put(5'(i));
         #1;
         chk("sweep_Y", longint'(Y), ref_y(5'(i)));
         chk("sweep_or", longint'(Y), longint'(|terms));
      end

      // Reset held 2 cycles with E=1.
      tick(5'b00001, 1'b1);
      tick(5'b00001, 1'b1);
      chk("rst_y_q", longint'(y_q), 0);
      chk("rst_y_rise", longint'(y_rise), 0);
      tick(5'b00001, 1'b0);
      chk("rel_y_q", longint'(y_q), 1);
      chk("rel_y_rise", longint'(y_rise), 1);
`ifdef BEXP_STATS_EN
      chk("cnt_1", longint'(hit_count), 1);
`endif
      tick(5'b00001, 1'b0);
      chk("hold_y_rise", longint'(y_rise), 0);
`ifdef BEXP_STATS_EN
      chk("cnt_2", longint'(hit_count), 2);
      tick(5'b00001, 1'b0);
      chk("cnt_3", longint'(hit_count), 3);
      tick(5'b00001, 1'b0);
      chk("cnt_sat4", longint'(hit_count), 3);
      tick(5'b00001, 1'b0);
      chk("cnt_sat5", longint'(hit_count), 3);
      tick(5'b00001, 1'b1);
      chk("cnt_rst", longint'(hit_count), 0);
      tick(5'b00001, 1'b0);
`endif

      // Toggle sequence Y = 0,1,1,0,1 via mixed terms.
      tgl[0] = 5'b10100; tgl[1] = 5'b11000;
      tgl[2] = 5'b00110; tgl[3] = 5'b01010;
      tgl[4] = 5'b00001;
      rexp[0] = 0; rexp[1] = 1; rexp[2] = 0;
      rexp[3] = 0; rexp[4] = 1;
      for (int i = 0; i < 5; i++) begin
         tick(tgl[i], 1'b0);
         chk("toggle_rise", longint'(y_rise), rexp[i]);
      end

      // Randomized run with occasional resets.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         put(5'($urandom));
         rst = ($urandom_range(0, 24) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #3;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
